// File: rtl/bias_l17_pkg.sv
// Shared widths and loader state encoding for the layer-17 bias bank loader.
package bias_l17_pkg;
    localparam int BIAS_W  = 18;
    localparam int N_BANKS = 4;

    typedef enum logic [1:0] {IDLE, LOAD, DONE} loader_state_t;
endpackage

// File: rtl/bias_word_packer_l17.sv
// Packs accepted bias words into lanes, lane 0 first; strobes last_word on the final lane.
// The packed vector already carries the current word in its lane so the bank commits on that edge.
module bias_word_packer_l17
    import bias_l17_pkg::*;
#(
    parameter int N_LANES = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       accept,
    input  logic [BIAS_W-1:0]          word,
    output logic [N_LANES*BIAS_W-1:0]  packed_vec,
    output logic                       last_word
);
    localparam int CW = (N_LANES > 1) ? $clog2(N_LANES) : 1;

    logic [CW-1:0]                word_cnt_q, word_cnt_d;
    logic [N_LANES*BIAS_W-1:0]    asm_q, asm_d;

    always_comb begin
        asm_d      = asm_q;
        word_cnt_d = word_cnt_q;
        last_word  = accept && (word_cnt_q == CW'(N_LANES - 1));
        packed_vec = asm_q;
        packed_vec[int'(word_cnt_q)*BIAS_W +: BIAS_W] = word;
        if (accept) begin
            asm_d      = packed_vec;
            word_cnt_d = last_word ? '0 : word_cnt_q + 1'b1;
        end
        if (clear) begin
            word_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt_q <= '0;
            asm_q      <= '0;
        end else begin
            word_cnt_q <= word_cnt_d;
            asm_q      <= asm_d;
        end
    end
endmodule

// File: rtl/bias_bank_loader_l17.sv
// Loads four bias banks from a serial word stream for the layer-17 bias mux.
// Optional sticky drop flag `err` exists only when BIAS_LOADER_ERR_EN is defined.
module bias_bank_loader_l17
    import bias_l17_pkg::*;
#(
    parameter int N_adder_tree = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [BIAS_W-1:0]               bias_in,
    input  logic                            bias_valid,
    output logic                            bias_ready,
    output logic [N_adder_tree*BIAS_W-1:0]  BIAS_1,
    output logic [N_adder_tree*BIAS_W-1:0]  BIAS_2,
    output logic [N_adder_tree*BIAS_W-1:0]  BIAS_3,
    output logic [N_adder_tree*BIAS_W-1:0]  BIAS_4,
    output logic [N_BANKS-1:0]              bank_valid,
    output logic                            done
`ifdef BIAS_LOADER_ERR_EN
    ,
    output logic                            err
`endif
);
    localparam int BW = N_adder_tree * BIAS_W;

    loader_state_t       state_q, state_d;
    logic [1:0]          bank_cnt_q, bank_cnt_d;
    logic [BW-1:0]       bank_q [N_BANKS];
    logic [BW-1:0]       bank_d [N_BANKS];
    logic [N_BANKS-1:0]  bank_valid_q, bank_valid_d;
    logic                done_q, done_d;
    logic                accept, launch, last_word;
    logic [BW-1:0]       packed_vec;

    assign bias_ready = (state_q == LOAD);
    assign accept     = bias_valid && bias_ready;
    // A start seen during LOAD is ignored, so only IDLE/DONE can launch.
    assign launch     = start && (state_q != LOAD);

    bias_word_packer_l17 #(.N_LANES(N_adder_tree)) u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (launch),
        .accept     (accept),
        .word       (bias_in),
        .packed_vec (packed_vec),
        .last_word  (last_word)
    );

    always_comb begin
        state_d      = state_q;
        bank_cnt_d   = bank_cnt_q;
        bank_d       = bank_q;
        bank_valid_d = bank_valid_q;
        case (state_q)
            LOAD: begin
                if (last_word) begin
                    bank_d[bank_cnt_q]       = packed_vec;
                    bank_valid_d[bank_cnt_q] = 1'b1;
                    bank_cnt_d               = bank_cnt_q + 2'd1;
                    if (bank_cnt_q == 2'(N_BANKS - 1)) begin
                        state_d = DONE;
                    end
                end
            end
            default: begin
                if (launch) begin
                    state_d      = LOAD;
                    bank_cnt_d   = '0;
                    bank_valid_d = '0;
                end
            end
        endcase
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            bank_cnt_q   <= '0;
            bank_valid_q <= '0;
            done_q       <= 1'b0;
            for (int k = 0; k < N_BANKS; k++) bank_q[k] <= '0;
        end else begin
            state_q      <= state_d;
            bank_cnt_q   <= bank_cnt_d;
            bank_valid_q <= bank_valid_d;
            done_q       <= done_d;
            bank_q       <= bank_d;
        end
    end

    assign BIAS_1     = bank_q[0];
    assign BIAS_2     = bank_q[1];
    assign BIAS_3     = bank_q[2];
    assign BIAS_4     = bank_q[3];
    assign bank_valid = bank_valid_q;
    assign done       = done_q;

`ifdef BIAS_LOADER_ERR_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q | (bias_valid && !bias_ready);
        if (launch) err_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign err = err_q;
`endif
endmodule

// File: tb/tb_bias_bank_loader_l17.sv
// Bench for bias_bank_loader_l17: small instance checked every cycle against a word-count model,
// plus a default-width instance for the all-ones load and the optional error flag.
module tb_bias_bank_loader_l17;
    localparam int N    = 2;
    localparam int BW   = N * 18;
    localparam int N16  = 16;
    localparam int BW16 = N16 * 18;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, start, bias_valid, bias_ready, done;
    logic [17:0]     bias_in;
    logic [BW-1:0]   b1, b2, b3, b4;
    logic [3:0]      bv;

    logic            start_16, valid_16, ready_16, done_16;
    logic [17:0]     in_16;
    logic [BW16-1:0] c1, c2, c3, c4;
    logic [3:0]      bv_16;
`ifdef BIAS_LOADER_ERR_EN
    logic            err, err_16;
`endif

    bias_bank_loader_l17 #(.N_adder_tree(N)) dut (
        .clk(clk), .rst(rst), .start(start), .bias_in(bias_in),
        .bias_valid(bias_valid), .bias_ready(bias_ready),
        .BIAS_1(b1), .BIAS_2(b2), .BIAS_3(b3), .BIAS_4(b4),
        .bank_valid(bv), .done(done)
`ifdef BIAS_LOADER_ERR_EN
        , .err(err)
`endif
    );

    bias_bank_loader_l17 #(.N_adder_tree(N16)) dut16 (
        .clk(clk), .rst(rst), .start(start_16), .bias_in(in_16),
        .bias_valid(valid_16), .bias_ready(ready_16),
        .BIAS_1(c1), .BIAS_2(c2), .BIAS_3(c3), .BIAS_4(c4),
        .bank_valid(bv_16), .done(done_16)
`ifdef BIAS_LOADER_ERR_EN
        , .err(err_16)
`endif
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [BW16-1:0] act, input logic [BW16-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: a load is just a running count of accepted words; word i lands in bank i/N, lane i%N.
    logic [17:0] m_lane [4][N];
    logic [17:0] m_pend [N];
    int          m_cnt;
    bit          m_loading, m_done, m_err;
    logic [3:0]  m_bv;

    function automatic logic [BW-1:0] m_vec(input int k);
        logic [BW-1:0] v;
        for (int j = 0; j < N; j++) v[j*18 +: 18] = m_lane[k][j];
        return v;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++)
                for (int j = 0; j < N; j++) m_lane[k][j] = '0;
            m_cnt = 0; m_loading = 0; m_done = 0; m_err = 0; m_bv = '0;
        end else if (m_loading) begin
            if (bias_valid) begin
                m_pend[m_cnt % N] = bias_in;
                m_cnt++;
                if (m_cnt % N == 0) begin
                    for (int j = 0; j < N; j++) m_lane[m_cnt/N - 1][j] = m_pend[j];
                    m_bv[m_cnt/N - 1] = 1'b1;
                end
                if (m_cnt == 4*N) begin
                    m_loading = 0;
                    m_done    = 1;
                end
            end
        end else begin
            if (bias_valid) m_err = 1;
            if (start) begin
                m_loading = 1; m_done = 0; m_cnt = 0; m_bv = '0; m_err = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("ready", bias_ready, m_loading);
            chk("bank_valid", bv, m_bv);
            chk("done", done, m_done);
            chk("BIAS_1", b1, m_vec(0));
            chk("BIAS_2", b2, m_vec(1));
            chk("BIAS_3", b3, m_vec(2));
            chk("BIAS_4", b4, m_vec(3));
`ifdef BIAS_LOADER_ERR_EN
            chk("err", err, m_err);
`endif
        end
    end

    task automatic drv(input bit s, input bit v, input logic [17:0] d);
        @(posedge clk); #1;
        start = s; bias_valid = v; bias_in = d;
        start_16 = 1'b0; valid_16 = 1'b0;
    endtask

    task automatic drv16(input bit s, input bit v, input logic [17:0] d);
        @(posedge clk); #1;
        start_16 = s; valid_16 = v; in_16 = d;
        start = 1'b0; bias_valid = 1'b0;
    endtask

    task automatic do_rst();
        @(posedge clk); #1;
        rst = 1'b1; start = 1'b0; bias_valid = 1'b0; start_16 = 1'b0; valid_16 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [BW-1:0] e;
        rst = 1'b1; start = 1'b0; bias_valid = 1'b0; bias_in = '0;
        start_16 = 1'b0; valid_16 = 1'b0; in_16 = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cmp_en = 1'b1;

        @(negedge clk);
        chk("rst_bias1", b1, '0);
        chk("rst_bank_valid", bv, '0);
        chk("rst_done", done, 1'b0);
        chk("rst_ready", bias_ready, 1'b0);

        drv16(0, 1, 18'h3FFFF);
        drv16(0, 0, '0);
        @(negedge clk);
`ifdef BIAS_LOADER_ERR_EN
        chk("err16_set", err_16, 1'b1);
`endif
        chk("ready16_idle", ready_16, 1'b0);
        drv16(1, 0, '0);
        drv16(0, 0, '0);
        @(negedge clk);
`ifdef BIAS_LOADER_ERR_EN
        chk("err16_clr", err_16, 1'b0);
`endif
        chk("ready16_load", ready_16, 1'b1);
        chk("bias16_dropped", c1, '0);
        for (int i = 0; i < 64; i++) drv16(0, 1, 18'h3FFFF);
        drv16(0, 0, '0);
        @(negedge clk);
        chk("c1_ones", c1, {BW16{1'b1}});
        chk("c4_ones", c4, {BW16{1'b1}});
        chk("bv16_full", bv_16, 4'hF);
        chk("done16", done_16, 1'b1);

        drv(1, 0, '0);
        for (int w = 1; w <= 8; w++) drv(0, 1, 18'(w));
        drv(0, 0, '0);
        @(negedge clk);
        e = {18'd2, 18'd1}; chk("full_bias1", b1, e);
        e = {18'd4, 18'd3}; chk("full_bias2", b2, e);
        e = {18'd6, 18'd5}; chk("full_bias3", b3, e);
        e = {18'd8, 18'd7}; chk("full_bias4", b4, e);
        chk("full_done", done, 1'b1);
        chk("full_bv", bv, 4'hF);

        drv(1, 0, '0);
        for (int w = 1; w <= 8; w++) begin
            drv(0, 1, 18'(w));
            drv(0, 0, '0);
        end
        @(negedge clk);
        e = {18'd6, 18'd5}; chk("gap_bias3", b3, e);
        chk("gap_done", done, 1'b1);

        drv(1, 0, '0);
        drv(0, 1, 18'd9);
        drv(0, 1, 18'd10);
        drv(0, 0, '0);
        @(negedge clk);
        chk("reload_bv", bv, 4'b0001);
        e = {18'd10, 18'd9}; chk("reload_bias1", b1, e);
        e = {18'd4, 18'd3};  chk("reload_bias2", b2, e);
        chk("reload_done", done, 1'b0);

        drv(1, 0, '0);
        for (int w = 1; w <= 3; w++) drv(0, 1, 18'(w));
        do_rst();
        @(negedge clk);
        chk("abort_bias1", b1, '0);
        chk("abort_bias2", b2, '0);
        chk("abort_ready", bias_ready, 1'b0);
        for (int w = 1; w <= 3; w++) drv(0, 1, 18'(w));
        drv(0, 0, '0);
        @(negedge clk);
        chk("nostart_bias1", b1, '0);
        chk("nostart_ready", bias_ready, 1'b0);

        repeat (500) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 2)       do_rst();
            else if (r < 12) drv(1, $urandom_range(0, 1) == 1, 18'($urandom));
            else             drv(0, $urandom_range(0, 99) < 75, 18'($urandom));
        end
        drv(0, 0, '0);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
